// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
// Channel FSM encoding is fixed so clk_out/active decode directly from state bits.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'b00,
        HIGH    = 2'b01,
        LOW     = 2'b10
    } clkdiv_state_e;

    localparam int unsigned CLKDIV_DEFAULT_HALF = 100;

    function automatic logic clkdiv_is_active(input clkdiv_state_e s);
        return s != STOPPED;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divided-clock channel: STOPPED/HIGH/LOW FSM, phase counter, active and pending half-period.
// run/step to clk_out+tick in one cycle; no backpressure. step_i exists only with CLKDIV_STEP_EN.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] div_value_i,
    input  logic             div_load_i,
    input  logic             run_i,
`ifdef CLKDIV_STEP_EN
    input  logic             step_i,
`endif
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    clkdiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half_m1;
    logic             wrap;
    logic             step_req;

    // hp==0 behaves as a half-period of one cycle.
    assign half_m1 = (hp_q == '0) ? '0 : hp_q - ONE;
    assign wrap    = (cnt_q == half_m1);

`ifdef CLKDIV_STEP_EN
    logic step_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_i;
        end
    end

    // Edge-qualified so a long step pulse still yields a single period.
    assign step_req = step_i & ~step_q;
`else
    assign step_req = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (run_i || step_req) state_d = HIGH;
            HIGH:    if (wrap) state_d = LOW;
            LOW:     if (wrap) state_d = run_i ? HIGH : STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    always_comb begin
        tick_d    = (state_d == HIGH) && (state_q != HIGH);
        clk_out_o = (state_q == HIGH);
        active_o  = clkdiv_is_active(state_q);
        tick_o    = tick_q;
    end

    always_comb begin
        cnt_d    = '0;
        hp_d     = hp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (state_q == STOPPED) begin
            if (div_load_i) begin
                hp_d     = div_value_i;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                // A load that landed on the stopping wrap takes effect here.
                hp_d     = pend_q;
                pend_v_d = 1'b0;
            end
        end else begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            if ((state_q == LOW) && wrap && pend_v_q) begin
                hp_d     = pend_q;
                pend_v_d = 1'b0;
            end
            if (div_load_i) begin
                pend_d   = div_value_i;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            hp_q     <= HP_RST;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// CHANNELS independent glitch-free divided clocks with per-period tick; registered outputs, no backpressure.
// Optional CLKDIV_STEP_EN adds a broadcast single-period step input.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*CNT_W-1:0] div_value,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS-1:0]       run,
`ifdef CLKDIV_STEP_EN
    input  logic                      step,
`endif
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       active
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clock_divider_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .div_value_i (div_value[i*CNT_W +: CNT_W]),
            .div_load_i  (div_load[i]),
            .run_i       (run[i]),
`ifdef CLKDIV_STEP_EN
            .step_i      (step),
`endif
            .clk_out_o   (clk_out[i]),
            .tick_o      (tick[i]),
            .active_o    (active[i])
        );
    end

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench: stimulus queues expected HIGH/LOW phase lengths, monitor measures and compares them.
module tb_clock_divider;

    localparam logic [1:0] LV_HI = 2'b11;
    localparam logic [1:0] LV_LO = 2'b10;

    typedef struct {
        logic [1:0] lvl;
        int         len;
    } seg_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] div_value;
    logic [1:0]  div_load;
    logic [1:0]  run;
`ifdef CLKDIV_STEP_EN
    logic        step;
`endif
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  active;

    int   checks   = 0;
    int   failures = 0;
    seg_t q0[$];
    seg_t q1[$];
    logic [1:0] prev [2] = '{2'b00, 2'b00};
    int   seg_len [2]    = '{0, 0};
    int   tick_cnt [2]   = '{0, 0};
    int   exp_ticks [2]  = '{0, 0};
    logic [1:0] cur_m;

    clock_divider dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .div_value (div_value),
        .div_load  (div_load),
        .run       (run),
`ifdef CLKDIV_STEP_EN
        .step      (step),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(input int c, input logic [1:0] lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        if (c == 0) q0.push_back(s);
        else        q1.push_back(s);
    endtask

    task automatic push_per(input int c, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            push_seg(c, LV_HI, h);
            push_seg(c, LV_LO, h);
        end
        exp_ticks[c] += n;
    endtask

    task automatic seg_end(input int c, input logic [1:0] lvl, input int len);
        seg_t e;
        int   empty;
        empty = (c == 0) ? int'(q0.size() == 0) : int'(q1.size() == 0);
        if (empty != 0) begin
            checks++;
            failures++;
            $display("FAIL seg_unexpected ch%0d: got level %b len %0d, required no phase", c, lvl, len);
        end else begin
            e = (c == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("seg_level ch%0d", c), int'(lvl), int'(e.lvl));
            chk($sformatf("seg_len ch%0d lvl%b", c, e.lvl), len, e.len);
        end
    endtask

    // Output monitor: a phase ends whenever {active,clk_out} changes.
    always @(negedge clock) begin
        for (int c = 0; c < 2; c++) begin
            cur_m = {active[c], clk_out[c]};
            if (!reset_n) begin
                prev[c]    = 2'b00;
                seg_len[c] = 0;
            end else begin
                if (tick[c]) tick_cnt[c]++;
                if (cur_m != prev[c]) begin
                    if (prev[c] != 2'b00) seg_end(c, prev[c], seg_len[c]);
                    chk($sformatf("tick_at_phase_start ch%0d", c), int'(tick[c]), int'(cur_m == LV_HI));
                    prev[c]    = cur_m;
                    seg_len[c] = 1;
                end else begin
                    if (tick[c]) chk($sformatf("stray_tick ch%0d", c), 1, 0);
                    seg_len[c]++;
                end
            end
        end
    end

    task automatic wait_stop(input int c, input int budget);
        int n;
        n = 0;
        while (active[c] && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("stop_within_budget ch%0d", c), int'(active[c]), 0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        run       = 2'b00;
        div_load  = 2'b00;
        div_value = '0;
`ifdef CLKDIV_STEP_EN
        step      = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("reset clk_out", int'(clk_out), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset active", int'(active), 0);
        @(posedge clock); #2 reset_n = 1'b1;

        // Default half-period of 100 on channel 0, two periods.
        @(posedge clock); #1 run[0] = 1'b1;
        push_per(0, 100, 2);
        @(negedge clock);
        chk("start_not_early ch0", int'(clk_out[0]), 0);
        @(posedge clock); @(negedge clock);
        chk("start clk_out ch0", int'(clk_out[0]), 1);
        chk("start tick ch0", int'(tick[0]), 1);
        chk("idle clk_out ch1", int'(clk_out[1]), 0);
        chk("idle active ch1", int'(active[1]), 0);
        repeat (250) @(posedge clock);
        #1 run[0] = 1'b0;
        wait_stop(0, 400);

        // Channel 1 at 5, reload 3 mid-HIGH, then reload 6 on a LOW wrap.
        @(posedge clock); #1 div_value[16 +: 16] = 16'd5; div_load[1] = 1'b1; run[1] = 1'b1;
        push_per(1, 5, 1);
        push_per(1, 3, 2);
        push_per(1, 6, 1);
        @(posedge clock); #1 div_load[1] = 1'b0;
        @(posedge clock); #1 div_value[16 +: 16] = 16'd3; div_load[1] = 1'b1;
        @(posedge clock); #1 div_load[1] = 1'b0;
        repeat (13) @(posedge clock);
        #1 div_value[16 +: 16] = 16'd6; div_load[1] = 1'b1;
        @(posedge clock); #1 div_load[1] = 1'b0;
        repeat (8) @(posedge clock);
        #1 run[1] = 1'b0;
        wait_stop(1, 60);

        // hp=0 loaded with run in the same cycle: toggle every cycle.
        @(posedge clock); #1 div_value[0 +: 16] = 16'd0; div_load[0] = 1'b1; run[0] = 1'b1;
        push_per(0, 1, 3);
        @(posedge clock); #1 div_load[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1 run[0] = 1'b0;
        wait_stop(0, 20);

        // hp=4, run dropped early in HIGH: full period still completes.
        @(posedge clock); #1 div_value[16 +: 16] = 16'd4; div_load[1] = 1'b1; run[1] = 1'b1;
        push_per(1, 4, 1);
        @(posedge clock); #1 div_load[1] = 1'b0;
        repeat (2) @(posedge clock);
        #1 run[1] = 1'b0;
        wait_stop(1, 30);
        chk("stopped clk_out ch1", int'(clk_out[1]), 0);
        repeat (20) @(negedge clock);

        // Asynchronous reset in the middle of a HIGH phase.
        @(posedge clock); #1 div_value[0 +: 16] = 16'd10; div_load[0] = 1'b1; run[0] = 1'b1;
        exp_ticks[0] += 1;
        @(posedge clock); #1 div_load[0] = 1'b0;
        @(posedge clock); @(posedge clock);
        #2 reset_n = 1'b0; run[0] = 1'b0;
        #1;
        chk("async reset clk_out ch0", int'(clk_out[0]), 0);
        chk("async reset active ch0", int'(active[0]), 0);
        repeat (3) @(negedge clock);
        @(posedge clock); #2 reset_n = 1'b1;
        @(negedge clock);
        chk("post reset clk_out", int'(clk_out), 0);
        chk("post reset active", int'(active), 0);
        @(posedge clock); #1 run[0] = 1'b1;
        push_per(0, 100, 1);
        repeat (3) @(posedge clock);
        #1 run[0] = 1'b0;
        wait_stop(0, 400);

`ifdef CLKDIV_STEP_EN
        // Single step on both channels at hp=2, with a three-cycle pulse.
        @(posedge clock); #1 div_value = {16'd2, 16'd2}; div_load = 2'b11;
        @(posedge clock); #1 div_load = 2'b00; step = 1'b1;
        push_per(0, 2, 1);
        push_per(1, 2, 1);
        @(posedge clock); @(negedge clock);
        chk("step seq0 ch1", int'(clk_out[1]), 1);
        @(posedge clock); @(negedge clock);
        chk("step seq1 ch1", int'(clk_out[1]), 1);
        @(posedge clock); #1 step = 1'b0;
        @(negedge clock);
        chk("step seq2 ch1", int'(clk_out[1]), 0);
        @(posedge clock); @(negedge clock);
        chk("step seq3 ch1", int'(clk_out[1]), 0);
        @(posedge clock); @(negedge clock);
        chk("step done active ch1", int'(active[1]), 0);

        // Step while channel 1 runs: ignored there, stopped channel 0 steps once.
        @(posedge clock); #1 run[1] = 1'b1;
        push_per(1, 2, 2);
        @(posedge clock); #1 step = 1'b1;
        push_per(0, 2, 1);
        @(posedge clock); #1 step = 1'b0;
        repeat (4) @(posedge clock);
        #1 run[1] = 1'b0;
        wait_stop(1, 20);
        wait_stop(0, 20);
`endif

        repeat (20) @(negedge clock);
        chk("pending phases ch0", q0.size(), 0);
        chk("pending phases ch1", q1.size(), 0);
        chk("tick count ch0", tick_cnt[0], exp_ticks[0]);
        chk("tick count ch1", tick_cnt[1], exp_ticks[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
